keypad_scan: RTL and testbench
==============================

# keypad_scan

Time-multiplexed 4x4 matrix keypad scanner for a Digilent Pmod KYPD on the BASYS3, the input-side counterpart of the seven-segment digit multiplexer. It strobes one active-low column at a time from a free-running divider, samples the active-low rows, debounces whole-keypad scan frames, and reports one debounced key code with a single-cycle press strobe. It sits between the Pmod pins and game/control logic, and its key code can feed the display multiplexer directly.

## Interface
- NUMSVAR, 16: log2 of clock ticks per column slot; one frame is 2^(NUMSVAR+2) ticks.
- DEBOUNCE, 4: number of consecutive identical frames required before a frame is accepted (range 1–15).
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- col  output  4  active-low column drive; exactly one bit low at all times.
- row  input  4  active-low row sense, externally pulled up; asynchronous to clk.
- key  output  4  code of the last accepted single key, equal to 4*row_index + col_index.
- key_valid  output  1  one-cycle pulse when a new single key is accepted.
- key_down  output  1  high while the accepted frame contains at least one pressed key.
- multi  output  1  high while the accepted frame contains two or more pressed keys.

## Operation
- Divider S has NUMSVAR+2 bits, resets to 0, and increments every cycle, wrapping.
- Column index ci = S[NUMSVAR+1:NUMSVAR]. col = ~(4'b0001 << ci), decoded combinationally from S.
- row passes through a 2-flop synchronizer and is inverted to active-high rs.
- Sample point: the cycle in which S[NUMSVAR-1:0] is all ones. At that cycle, rs is written into snapshot bits [4*r+ci] for r = 0..3.
- Frame commit: the sample cycle with ci = 3. The frame equals the snapshot with the ci = 3 bits taken from the current rs, so the frame is never one column stale.
- At each commit, compare the frame to the previous frame (prev):
  - Equal: cnt = min(cnt+1, DEBOUNCE).
  - Different: cnt = 0.
  - Then prev is set to the frame.
- Acceptance: when cnt reaches DEBOUNCE (transition into DEBOUNCE, or DEBOUNCE = 1 with an equal frame) and the frame differs from the accepted frame acc, acc is set to the frame.
- Outputs update on acceptance:
  - key_down = |acc.
  - multi = (popcount(acc) ≥ 2).
  - If acc has exactly one bit set: key = its index, and key_valid pulses.
  - Otherwise key holds its previous value and no pulse is issued.
- Release (acc becomes 0): key_down = 0, multi = 0, key holds, no pulse.
- Multi-key to single-key (one key released out of two): pulses with the remaining key, even if it equals the previous key.
- Same single key held: acc is unchanged, so no repeat pulse.
- Reset values: S = 0 (col = 4'b1110), snapshot = 0, prev = 0, acc = 0, cnt = 0, key = 0, key_valid = 0, key_down = 0, multi = 0, synchronizer flops = 0.
- Reset asserted mid-frame discards the partial snapshot and the debounce history. Scanning restarts at column 0 on the first cycle after reset deasserts.

## Timing
- Column slot is 2^NUMSVAR cycles (655.36 µs at the defaults). Frame is 2.62 ms.
- Row settling before the sample is 2^NUMSVAR − 3 cycles, after the column change plus the 2-cycle synchronizer.
- key, key_down, multi and key_valid are all registered. They change on the cycle after the accepting commit. key_valid is high for exactly that one cycle.
- Press-to-pulse latency: from (DEBOUNCE+1) frames up to (DEBOUNCE+2) frames plus 1 cycle, depending on press phase. A press that first lands mid-frame may produce one partial, mismatching frame.
- Bounce shorter than one frame restarts cnt and delays acceptance only.
- Counter wrap from all-ones to 0 is seamless: column 3 commit, then column 0 slot.

## Test plan
All scenarios use NUMSVAR = 2 and DEBOUNCE = 2, giving 4-cycle slots and 16-cycle frames.
- Reset: after reset, col = 4'b1110 and every output is 0. col cycles 1110 → 1101 → 1011 → 0111, 4 cycles each, for 64 cycles with no key_valid.
- Single press: model pulls row[2] low only while col[1] is low → key = 9, key_valid for exactly one cycle, key_down = 1, multi = 0. The pulse occurs between frames 3 and 4 after the press. Holding for 10 frames produces no further pulse.
- Bounce: toggle the row-2/col-1 contact every 10 cycles for 5 frames, then hold → no pulse during bouncing, then exactly one pulse with key = 9.
- Release: release after acceptance → key_down falls about 3 frames later, key stays 9, no key_valid.
- Two keys: hold key 0 and key 15 → multi = 1, key_down = 1, no pulse. Release key 0 → one pulse with key = 15 and multi = 0.
- Reset mid-debounce: assert reset one frame after a press for 1 cycle, keeping the key held → all outputs 0. One pulse with the key follows, timed from the reset release.

Source files
------------

// File: rtl/keypad_scan_if.sv
// Pmod KYPD pin bundle plus the debounced key report seen by control logic.
interface keypad_scan_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_down;
  logic       multi;

  modport master (output col, key, key_valid, key_down, multi, input row);
  modport slave  (input col, key, key_valid, key_down, multi, output row);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one active-low column per slot, whole-frame
// debounce, and a single-cycle strobe whenever a new single key is accepted.
module keypad_scan #(
  parameter int NUMSVAR  = 16,
  parameter int DEBOUNCE = 4
) (
  input logic           clk,
  input logic           reset,
  keypad_scan_if.master kp
);
  localparam int         SW = NUMSVAR + 2;
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic [SW-1:0] s_q;
  logic [3:0]    sync1_q, sync2_q, rs;
  logic [15:0]   snap_q, snap_d, prev_q, acc_q, frame;
  logic [3:0]    cnt_q, cnt_d, key_q, key_d;
  logic          kv_q, kv_d, kd_q, kd_d, multi_q, multi_d;
  logic [1:0]    ci;
  logic          sample, commit, accept;
  logic [4:0]    ones;
  logic [3:0]    idx;

  assign ci     = s_q[SW-1:NUMSVAR];
  assign sample = &s_q[NUMSVAR-1:0];
  assign commit = sample && (ci == 2'd3);
  assign rs     = ~sync2_q;
  assign kp.col = ~(4'b0001 << ci);

  always_comb begin
    snap_d = snap_q;
    if (sample)
      for (int r = 0; r < 4; r++) snap_d[{2'(r), ci}] = rs[r];
    // At the commit slot snap_d already carries the live column-3 rows.
    frame = snap_d;

    cnt_d = cnt_q;
    if (commit) begin
      if (frame != prev_q)  cnt_d = '0;
      else if (cnt_q != DB) cnt_d = cnt_q + 4'd1;
    end
    // Once cnt sits at DB, prev already equals acc, so this fires only on a
    // fresh arrival at DB (or every equal frame when DB is 1).
    accept = commit && (cnt_d == DB) && (frame != acc_q);

    ones = '0;
    idx  = '0;
    for (int i = 0; i < 16; i++)
      if (frame[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end

    key_d   = key_q;
    kd_d    = kd_q;
    multi_d = multi_q;
    kv_d    = 1'b0;
    if (accept) begin
      kd_d    = |frame;
      multi_d = (ones >= 5'd2);
      if (ones == 5'd1) begin
        key_d = idx;
        kv_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q     <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      snap_q  <= '0;
      prev_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      kv_q    <= 1'b0;
      kd_q    <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      s_q     <= s_q + SW'(1);
      sync1_q <= kp.row;
      sync2_q <= sync1_q;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      if (commit) prev_q <= frame;
      if (accept) acc_q  <= frame;
      key_q   <= key_d;
      kv_q    <= kv_d;
      kd_q    <= kd_d;
      multi_q <= multi_d;
    end
  end

  assign kp.key       = key_q;
  assign kp.key_valid = kv_q;
  assign kp.key_down  = kd_q;
  assign kp.multi     = multi_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a frame-level keypad model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_keypad_scan;
  localparam int N = 2, D = 2, SLOT = 4, FRM = 16;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_if kif();
  keypad_scan #(.NUMSVAR(N), .DEBOUNCE(D)) dut (.clk(clk), .reset(reset), .kp(kif));

  // Physical keypad: a pressed key shorts its row low while its column is low.
  logic [15:0] pressed = '0;
  always_comb begin
    kif.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !kif.col[c]) kif.row[r] = 1'b0;
  end

  int vectors = 0, miscompares = 0;
  int t = 0, pulses = 0, pulse_t = -1;
  bit started = 0;
  logic [15:0] snapm, prevm, accm;
  int run;
  logic [3:0] rq1, rq2, ek, ecol;
  logic ekv, ekd, emu;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", nm, t, act, exp);
    end
  endtask

  // Model: rows seen at a sample are those driven two cycles earlier; a frame
  // is accepted once D+1 identical frames (reset counts as an all-zero frame)
  // have been seen and it differs from the accepted one.
  always @(negedge clk) begin
    if (started) begin
      ecol = ~(4'b0001 << ((t / SLOT) % 4));
      cmp("col", 32'(kif.col), 32'(ecol));
      cmp("key", 32'(kif.key), 32'(ek));
      cmp("key_valid", 32'(kif.key_valid), 32'(ekv));
      cmp("key_down", 32'(kif.key_down), 32'(ekd));
      cmp("multi", 32'(kif.multi), 32'(emu));
      if (kif.key_valid === 1'b1) begin
        pulses++;
        pulse_t = t;
      end
    end
    if (reset) begin
      started = 1;
      t = 0; snapm = '0; prevm = '0; accm = '0; run = 1;
      ek = '0; ekv = 0; ekd = 0; emu = 0;
      rq1 = '0; rq2 = '0;
    end else if (started) begin
      ekv = 0;
      if (t % SLOT == SLOT - 1) begin
        for (int r = 0; r < 4; r++) snapm[4*r + (t / SLOT) % 4] = ~rq2[r];
        if ((t / SLOT) % 4 == 3) begin
          run = (snapm == prevm) ? run + 1 : 1;
          prevm = snapm;
          if (run >= D + 1 && snapm != accm) begin
            accm = snapm;
            ekd = |snapm;
            emu = ($countones(snapm) >= 2);
            if ($countones(snapm) == 1) begin
              for (int i = 0; i < 16; i++) if (snapm[i]) ek = 4'(i);
              ekv = 1;
            end
          end
        end
      end
      rq2 = rq1;
      rq1 = kif.row;
      t++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_pulse(input int p0, input int bound);
    for (int i = 0; i < bound && pulses == p0; i++) wait_cyc(1);
  endtask

  task automatic outs_zero(input string tag);
    cmp({tag, "_col"}, 32'(kif.col), 32'h0000000E);
    cmp({tag, "_key"}, 32'(kif.key), 0);
    cmp({tag, "_kv"}, 32'(kif.key_valid), 0);
    cmp({tag, "_kd"}, 32'(kif.key_down), 0);
    cmp({tag, "_multi"}, 32'(kif.multi), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int p0, lat;
  initial begin
    // Reset and idle scan
    wait_cyc(3);
    reset = 1'b0;
    outs_zero("reset");
    p0 = pulses;
    wait_cyc(4);
    cmp("col_slot1", 32'(kif.col), 32'h0000000D);
    wait_cyc(60);
    cmp("idle_pulses", pulses - p0, 0);

    // Single press of key 9 at a frame start (t=64)
    p0 = pulses;
    pressed[9] = 1'b1;
    wait_pulse(p0, 120);
    cmp("press_pulses", pulses - p0, 1);
    lat = pulse_t - 64;
    cmp("press_latency_ok", 32'(lat >= (D+1)*FRM && lat <= (D+2)*FRM + 1), 1);
    cmp("press_pulse_t", pulse_t, 112);
    cmp("press_key", 32'(kif.key), 9);
    cmp("press_kd", 32'(kif.key_down), 1);
    cmp("press_multi", 32'(kif.multi), 0);
    cmp("press_kv_low", 32'(kif.key_valid), 0);
    p0 = pulses;
    wait_cyc(10 * FRM);
    cmp("hold_no_repeat", pulses - p0, 0);

    // Release
    pressed[9] = 1'b0;
    wait_cyc(32);
    cmp("release_kd_early", 32'(kif.key_down), 1);
    wait_cyc(28);
    cmp("release_kd", 32'(kif.key_down), 0);
    cmp("release_key", 32'(kif.key), 9);
    cmp("release_pulses", pulses - p0, 0);

    // Bounce every 10 cycles for 5 frames, then hold
    do_reset();
    wait_cyc(32);
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      pressed[9] = (i % 2 == 0);
      wait_cyc(10);
    end
    pressed[9] = 1'b1;
    cmp("bounce_quiet", pulses - p0, 0);
    wait_pulse(p0, 120);
    cmp("bounce_pulses", pulses - p0, 1);
    cmp("bounce_pulse_t", pulse_t, 144);
    cmp("bounce_key", 32'(kif.key), 9);

    // Two keys, then release one
    pressed = '0;
    do_reset();
    p0 = pulses;
    pressed[0] = 1'b1;
    pressed[15] = 1'b1;
    wait_cyc(6 * FRM);
    cmp("two_multi", 32'(kif.multi), 1);
    cmp("two_kd", 32'(kif.key_down), 1);
    cmp("two_key", 32'(kif.key), 0);
    cmp("two_pulses", pulses - p0, 0);
    pressed[0] = 1'b0;
    wait_pulse(p0, 120);
    cmp("one_left_pulses", pulses - p0, 1);
    cmp("one_left_key", 32'(kif.key), 15);
    cmp("one_left_multi", 32'(kif.multi), 0);
    cmp("one_left_kd", 32'(kif.key_down), 1);

    // Reset during debounce with key 6 held
    pressed = '0;
    do_reset();
    wait_cyc(32);
    pressed[6] = 1'b1;
    wait_cyc(16);
    p0 = pulses;
    do_reset();
    outs_zero("midrst");
    cmp("midrst_no_early", pulses - p0, 0);
    wait_pulse(p0, 120);
    cmp("midrst_pulses", pulses - p0, 1);
    cmp("midrst_pulse_t", pulse_t, 48);
    cmp("midrst_key", 32'(kif.key), 6);
    wait_cyc(FRM);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
